// File: rtl/rptr_empty_lvl.sv
// Read-side pointer and status block for a dual-clock FIFO.
// Keeps the binary read pointer and its Gray copy for the write-domain
// synchronizer. Drives the RAM read address and a registered empty flag.
// Fill level, almost-empty and sticky underflow are all derived from the
// write pointer after it has been synchronized into rclk.
module rptr_empty_lvl #(
    parameter int BUF_SIZE  = 8,
    parameter int AE_THRESH = 1,
    localparam int A        = $clog2(BUF_SIZE)
) (
    input  logic         rclk,
    input  logic         rrst_n,
    input  logic         rinc,
    input  logic [A:0]   rq2_wptr,
    input  logic         rclr_uf,
    output logic [A-1:0] raddr,
    output logic [A:0]   rptr,
    output logic         rempty,
    output logic         ralmost_empty,
    output logic [A:0]   rlevel,
    output logic         runderflow
);

    localparam logic [A:0] AE_LIM = AE_THRESH[A:0];

    logic [A:0] rbin;
    logic [A:0] rbinnext;
    logic [A:0] rgraynext;
    logic [A:0] rq2_wbin;
    logic [A:0] lvl_next;
    logic       pop;

    // A pop only happens when there is something to read.
    assign pop = rinc & ~rempty;

    // Next read pointer (binary and Gray), plus the level it leaves behind.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        rbinnext  = rbin + {{A{1'b0}}, pop};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        lvl_next  = rq2_wbin - rbinnext;
    end

    // Gray-to-binary of the synchronized write pointer: bit i is the XOR of Gray bits i..A.
    always_comb begin
        rq2_wbin = '0;
        for (int i = 0; i <= A; i++) begin
            rq2_wbin[i] = ^(rq2_wptr >> i);
        end
    end

    // Pointer registers; rptr leaves straight from a flop so the crossing sees no glitches.
    always_ff @(posedge rclk or negedge rrst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
        if (!rrst_n) begin
            rbin <= '0;
            rptr <= '0;
        end else begin
            rbin <= rbinnext;
            rptr <= rgraynext;
        end
    end

    // Registered status: empty when all Gray bits match, level by modular subtraction.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rlevel        <= '0;
        end else begin
            rempty        <= (rgraynext == rq2_wptr);
            ralmost_empty <= (lvl_next <= AE_LIM);
            rlevel        <= lvl_next;
        end
    end

    // Sticky underflow; a new read-while-empty wins over a clear in the same cycle.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            runderflow <= 1'b0;
        end else begin
            runderflow <= (rinc & rempty) | (runderflow & ~rclr_uf);
        end
    end

    assign raddr = rbin[A-1:0];

endmodule
